// File: rtl/seq_multiplier.sv
// seq_multiplier -- multi-cycle unsigned shift-add multiplier (execute-stage MUL).
//
// One partial product is added per clock. The adder is WIDTH/4 four-bit
// carry-lookahead groups chained by their group carry. The hazard unit stalls
// on busy. The product is consumed in the single-cycle done pulse.
//
// Optional feature macro: SEQ_MULT_HI_EN
//   defined   -> prod_hi port present (upper WIDTH bits of a*b)
//   undefined -> prod_hi port and its register are absent; product unchanged
//
// Parameters
//   WIDTH    operand width, must be a multiple of 4 (one CLA group per nibble)
//
// Ports
//   clk      in   1      rising-edge clock
//   reset    in   1      synchronous, active-high; aborts RUN without done
//   start    in   1      request; operands sampled when start=1 and not RUN
//   a        in   WIDTH  multiplicand
//   b        in   WIDTH  multiplier
//   busy     out  1      1 while iterating (RUN)
//   done     out  1      one-cycle pulse, product valid
//   product  out  WIDTH  low WIDTH bits of a*b (registered)
//   prod_hi  out  WIDTH  high WIDTH bits of a*b (SEQ_MULT_HI_EN only)

module seq_multiplier #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
`ifdef SEQ_MULT_HI_EN
  ,
  output logic [WIDTH-1:0] prod_hi
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned NG = WIDTH / 4;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] product_q, product_d;
`ifdef SEQ_MULT_HI_EN
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
`endif

  // ---------------------------------------------------------------------------
  // Adder: acc[WIDTH-1:0] + (mplier[0] ? mcand : 0).
  // Each 4-bit group computes its internal carries by lookahead from the
  // incoming group carry. The last group carry lands in sum[WIDTH].
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] add_x, add_y;
  logic [WIDTH:0]   sum;
  logic [3:0]       grp_p, grp_g, grp_c;
  logic             grp_cin, grp_cout;

  always_comb begin
    add_x = acc_q[WIDTH-1:0];
    add_y = mplier_q[0] ? mcand_q : '0;
  end

  always_comb begin
    sum      = '0;
    grp_p    = '0;
    grp_g    = '0;
    grp_c    = '0;
    grp_cout = 1'b0;
    grp_cin  = 1'b0;
    for (int unsigned g = 0; g < NG; g++) begin
      grp_p    = add_x[4*g +: 4] ^ add_y[4*g +: 4];
      grp_g    = add_x[4*g +: 4] & add_y[4*g +: 4];
      grp_c[0] = grp_cin;
      grp_c[1] = grp_g[0] | (grp_p[0] & grp_cin);
      grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0])
               | (grp_p[1] & grp_p[0] & grp_cin);
      grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1])
               | (grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[2] & grp_p[1] & grp_p[0] & grp_cin);
      grp_cout = grp_g[3] | (grp_p[3] & grp_g[2])
               | (grp_p[3] & grp_p[2] & grp_g[1])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & grp_cin);
      sum[4*g +: 4] = grp_p ^ grp_c;
      grp_cin = grp_cout;
    end
    sum[WIDTH] = grp_cin;
  end

  // acc[WIDTH] is always zero after the shift; it exists so the adder carry
  // has a home before shifting and is never read on its own.
  logic acc_top_unused;
  always_comb acc_top_unused = acc_q[WIDTH];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (count_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy    = (state_q == S_RUN);
    done    = (state_q == S_DONE);
    product = product_q;
`ifdef SEQ_MULT_HI_EN
    prod_hi = prod_hi_q;
`endif
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    product_d = product_q;
`ifdef SEQ_MULT_HI_EN
    prod_hi_d = prod_hi_q;
`endif
    if (state_q == S_RUN) begin
      // {acc,mplier} <= {sum,mplier} >> 1
      acc_d    = {1'b0, sum[WIDTH:1]};
      mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
      count_d  = count_q + CW'(1);
      // Capture the result on the final iteration so it is already
      // registered during the done cycle.
      if (count_q == LAST) begin
        product_d = {sum[0], mplier_q[WIDTH-1:1]};
`ifdef SEQ_MULT_HI_EN
        prod_hi_d = sum[WIDTH:1];
`endif
      end
    end else if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      count_d  = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
`ifdef SEQ_MULT_HI_EN
      prod_hi_q <= '0;
`endif
    end else begin
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
`ifdef SEQ_MULT_HI_EN
      prod_hi_q <= prod_hi_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: a 64-bit instance driven from a
// vector table and hand sequences, plus an 8-bit instance.

module tb_seq_multiplier;

  localparam int W  = 64;
  localparam int W8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, start8;
  logic [63:0]   a, b;
  logic [7:0]    a8, b8;
  logic          busy, done, busy8, done8;
  logic [63:0]   product;
  logic [7:0]    product8;
`ifdef SEQ_MULT_HI_EN
  logic [63:0]   prod_hi;
  logic [7:0]    prod_hi8;
`endif

  seq_multiplier #(.WIDTH(W)) dut64 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
`ifdef SEQ_MULT_HI_EN
    , .prod_hi(prod_hi)
`endif
  );

  seq_multiplier #(.WIDTH(W8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
`ifdef SEQ_MULT_HI_EN
    , .prod_hi(prod_hi8)
`endif
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  logic mon_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] lo;
    logic [63:0] hi;
    int          done_cyc;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] lo;
    logic [63:0] hi;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start for one cycle and record the expected result and done cycle.
  task automatic issue(input logic [63:0] ea, input logic [63:0] eb,
                       input logic [63:0] elo, input logic [63:0] ehi);
    sb_t e;
    start = 1'b1;
    a = ea;
    b = eb;
    e.lo = elo;
    e.hi = ehi;
    e.done_cyc = cyc + 1 + W;
    sb.push_back(e);
    tick();
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < W + 10) begin
      tick();
      n++;
    end
    if (done !== 1'b1) begin
      total_cnt++;
      $display("FAIL %s: done never seen within %0d cycles", name, W + 10);
    end
  endtask

  // Scoreboard monitor: every cycle checks busy/done against the oldest
  // outstanding request, and the product on its done cycle.
  logic mon_exp_busy;
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      mon_exp_busy = (sb.size() > 0) && (cyc >= sb[0].done_cyc - W) && (cyc < sb[0].done_cyc);
      check("busy", 128'(busy), 128'(mon_exp_busy));
      if (sb.size() > 0 && cyc == sb[0].done_cyc) begin
        check("done_pulse", 128'(done), 128'(1'b1));
        check("product", 128'(product), 128'(sb[0].lo));
`ifdef SEQ_MULT_HI_EN
        check("prod_hi", 128'(prod_hi), 128'(sb[0].hi));
`endif
        void'(sb.pop_front());
      end else begin
        check("done_low", 128'(done), 128'(1'b0));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [127:0] full;
  logic [63:0]  ra, rb;
  logic [15:0]  full8;
  int           s8, n8;
  logic [63:0]  last_lo, last_hi;

  initial begin
    tbl[0] = '{64'd3, 64'd5, 64'd15, 64'd0};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE};
    tbl[2] = '{64'd0, 64'd12345, 64'd0, 64'd0};
    tbl[3] = '{64'd12345, 64'd0, 64'd0, 64'd0};
    tbl[4] = '{64'h8000_0000_0000_0000, 64'd2, 64'd0, 64'd1};
    tbl[5] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 64'd0};
    tbl[6] = '{64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 64'd1};
    tbl[7] = '{64'd7, 64'd9, 64'd63, 64'd0};
    tbl[8] = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};

    reset = 1'b1; start = 1'b0; start8 = 1'b0;
    a = '0; b = '0; a8 = '0; b8 = '0;
    repeat (2) tick();
    check("reset_busy", 128'(busy), 128'(1'b0));
    check("reset_done", 128'(done), 128'(1'b0));
    check("reset_product", 128'(product), 128'(0));
    check("reset_busy8", 128'(busy8), 128'(1'b0));
    check("reset_product8", 128'(product8), 128'(0));
`ifdef SEQ_MULT_HI_EN
    check("reset_prod_hi", 128'(prod_hi), 128'(0));
`endif
    reset = 1'b0;
    mon_en = 1'b1;
    tick();

    // Table vectors, each from IDLE, with a hold check afterwards.
    for (int i = 0; i < 9; i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].lo, tbl[i].hi);
      wait_done("table");
      tick();
      tick();
      check("hold_product", 128'(product), 128'(tbl[i].lo));
`ifdef SEQ_MULT_HI_EN
      check("hold_prod_hi", 128'(prod_hi), 128'(tbl[i].hi));
`endif
    end

    // Random vectors against a wide-multiply model.
    for (int i = 0; i < 4; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      full = {64'd0, ra} * {64'd0, rb};
      issue(ra, rb, full[63:0], full[127:64]);
      wait_done("random");
      tick();
    end

    // Start pulsed mid-RUN is ignored.
    issue(64'd7, 64'd9, 64'd63, 64'd0);
    repeat (10) tick();
    start = 1'b1; a = 64'd2; b = 64'd2;
    tick();
    start = 1'b0;
    wait_done("ignore_start");
    tick();

    // Reset at RUN cycle 30 aborts without done.
    issue(64'd100, 64'd200, 64'd20000, 64'd0);
    repeat (29) tick();
    check("run30_busy", 128'(busy), 128'(1'b1));
    reset = 1'b1;
    tick();
    sb.delete();
    check("abort_busy", 128'(busy), 128'(1'b0));
    check("abort_done", 128'(done), 128'(1'b0));
    check("abort_product", 128'(product), 128'(0));
    reset = 1'b0;
    repeat (W + 5) tick();
    issue(64'd11, 64'd13, 64'd143, 64'd0);
    wait_done("after_abort");
    tick();

    // Back-to-back: start in the done cycle.
    issue(64'd5, 64'd6, 64'd30, 64'd0);
    wait_done("b2b_first");
    last_lo = product;
    check("b2b_first_product", 128'(last_lo), 128'(30));
    issue(64'd10, 64'd10, 64'd100, 64'd0);
    check("b2b_no_gap", 128'(busy), 128'(1'b1));
    wait_done("b2b_second");
    tick();

    // 8-bit instance: FF*02 and random vectors.
    a8 = 8'hFF; b8 = 8'h02; start8 = 1'b1;
    s8 = cyc;
    tick();
    start8 = 1'b0;
    check("w8_busy", 128'(busy8), 128'(1'b1));
    n8 = 0;
    while (done8 !== 1'b1 && n8 < 30) begin
      tick();
      n8++;
    end
    check("w8_latency", 128'(cyc - s8), 128'(9));
    check("w8_product", 128'(product8), 128'(8'hFE));
`ifdef SEQ_MULT_HI_EN
    check("w8_prod_hi", 128'(prod_hi8), 128'(8'h01));
`endif
    tick();
    for (int i = 0; i < 3; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      full8 = {8'd0, a8} * {8'd0, b8};
      start8 = 1'b1;
      s8 = cyc;
      tick();
      start8 = 1'b0;
      n8 = 0;
      while (done8 !== 1'b1 && n8 < 30) begin
        tick();
        n8++;
      end
      check("w8r_latency", 128'(cyc - s8), 128'(9));
      check("w8r_product", 128'(product8), 128'(full8[7:0]));
`ifdef SEQ_MULT_HI_EN
      check("w8r_prod_hi", 128'(prod_hi8), 128'(full8[15:8]));
`endif
      tick();
    end

    repeat (3) tick();
    check("sb_drained", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
